// File: rtl/can_frame_pkg.sv
// Shared types and constants for the CAN transmit frame sequencer.
// Holds the sequencer state encoding, fixed field lengths and the DLC clamp helper.
package can_frame_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_SOF       = 4'd1,
        ST_ARB       = 4'd2,
        ST_CTRL      = 4'd3,
        ST_DATA      = 4'd4,
        ST_CRC       = 4'd5,
        ST_CRC_DELIM = 4'd6,
        ST_ACK_SLOT  = 4'd7,
        ST_ACK_DELIM = 4'd8,
        ST_EOF       = 4'd9,
        ST_IFS       = 4'd10
    } state_t;

    localparam int EOF_LEN = 7;
    localparam int IFS_LEN = 3;
    localparam int MAX_DLC = 8;

    // DLC codes above 8 still mean eight data bytes on the bus.
    function automatic logic [3:0] clamp_dlc(input logic [3:0] d);
        return (d > 4'(MAX_DLC)) ? 4'(MAX_DLC) : d;
    endfunction

endpackage

// File: rtl/seq_bit_counter.sv
// Bit-time counter for the fixed-length trailer fields of a CAN frame.
// Advances only on sample_point, clears whenever the sequencer changes state.
module seq_bit_counter (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_clear,
    input  logic       i_sample_point,
    input  logic [2:0] i_last,
    output logic       o_tc
);

    logic [2:0] r_count;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count <= 3'd0;
        end else if (i_clear) begin
            r_count <= 3'd0;
        end else if (i_sample_point && !o_tc) begin
            r_count <= r_count + 3'd1;
        end
    end

    // Terminal count: the current bit is the last bit of the field.
    assign o_tc = (r_count == i_last);

endmodule

// File: rtl/tx_frame_sequencer.sv
// CAN transmit frame sequencer: walks SOF..IFS, muxes field bits onto tx_bit.
// Optional ACK_CHECK_EN macro enables ACK slot readback via rx_bit and ack_error.
module tx_frame_sequencer
    import can_frame_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       sample_point,
    input  logic       Tx_request,
    input  logic       rtr,
    input  logic [3:0] dlc,
    input  logic       arb_bit,
    input  logic       control_bit,
    input  logic       data_bit,
    input  logic       crc_bit,
    input  logic       rtr_complete,
    input  logic       control_complete,
    input  logic       data_complete,
    input  logic       crc_complete,
    input  logic       rx_bit,
    output logic       arb_en,
    output logic       ctrl_en,
    output logic       data_en,
    output logic       crc_en,
    output logic       tx_bit,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       ack_error,
    output logic [3:0] state
);

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_dlc;
    logic       r_rtr;
    logic       r_tx_done;
    logic       w_done_set;
    logic       w_ack_err_set;
    logic       w_cnt_clear;
    logic       w_cnt_tc;
    logic [2:0] w_cnt_last;
    logic       w_skip_data;

    assign w_skip_data = r_rtr || (clamp_dlc(r_dlc) == 4'd0);

    always_comb begin
        w_cnt_last = 3'd0;
        case (r_state)
            ST_EOF:  w_cnt_last = 3'(EOF_LEN - 1);
            ST_IFS:  w_cnt_last = 3'(IFS_LEN - 1);
            default: w_cnt_last = 3'd0;
        endcase
    end

    // Abort (enable low or request withdrawn) outranks every bit-level advance.
    always_comb begin
        w_next        = r_state;
        w_done_set    = 1'b0;
        w_ack_err_set = 1'b0;
        if (r_state != ST_IDLE && (!enable || !Tx_request)) begin
            w_next = ST_IDLE;
        end else if (sample_point) begin
            case (r_state)
                ST_IDLE:      if (enable && Tx_request) w_next = ST_SOF;
                ST_SOF:       w_next = ST_ARB;
                ST_ARB:       if (rtr_complete) w_next = ST_CTRL;
                ST_CTRL:      if (control_complete) w_next = w_skip_data ? ST_CRC : ST_DATA;
                ST_DATA:      if (data_complete) w_next = ST_CRC;
                ST_CRC:       if (crc_complete) w_next = ST_CRC_DELIM;
                ST_CRC_DELIM: if (w_cnt_tc) w_next = ST_ACK_SLOT;
                ST_ACK_SLOT: begin
`ifdef ACK_CHECK_EN
                    if (rx_bit) begin
                        w_next        = ST_IDLE;
                        w_ack_err_set = 1'b1;
                    end else begin
                        w_next = ST_ACK_DELIM;
                    end
`else
                    if (w_cnt_tc) w_next = ST_ACK_DELIM;
`endif
                end
                ST_ACK_DELIM: if (w_cnt_tc) w_next = ST_EOF;
                ST_EOF:       if (w_cnt_tc) w_next = ST_IFS;
                ST_IFS: begin
                    if (w_cnt_tc) begin
                        w_next     = ST_IDLE;
                        w_done_set = 1'b1;
                    end
                end
                default:      w_next = ST_IDLE;
            endcase
        end
    end

    assign w_cnt_clear = (w_next != r_state);

    seq_bit_counter u_bit_counter (
        .i_clk          (clock),
        .i_rst_n        (reset_n),
        .i_clear        (w_cnt_clear),
        .i_sample_point (sample_point),
        .i_last         (w_cnt_last),
        .o_tc           (w_cnt_tc)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_dlc     <= 4'd0;
            r_rtr     <= 1'b0;
            r_tx_done <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_tx_done <= w_done_set;
            if (r_state == ST_IDLE && w_next == ST_SOF) begin
                r_dlc <= dlc;
                r_rtr <= rtr;
            end
        end
    end

`ifdef ACK_CHECK_EN
    logic r_ack_error;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_ack_error <= 1'b0;
        end else begin
            r_ack_error <= w_ack_err_set;
        end
    end

    assign ack_error = r_ack_error;
`else
    logic w_unused_ack;

    assign w_unused_ack = rx_bit ^ w_ack_err_set;
    assign ack_error    = 1'b0;
`endif

    always_comb begin
        tx_bit = 1'b1;
        case (r_state)
            ST_SOF:  tx_bit = 1'b0;
            ST_ARB:  tx_bit = arb_bit;
            ST_CTRL: tx_bit = control_bit;
            ST_DATA: tx_bit = data_bit;
            ST_CRC:  tx_bit = crc_bit;
            default: tx_bit = 1'b1;
        endcase
    end

    assign arb_en  = (r_state == ST_ARB);
    assign ctrl_en = (r_state == ST_CTRL);
    assign data_en = (r_state == ST_DATA);
    assign crc_en  = (r_state == ST_CRC);
    assign tx_busy = (r_state != ST_IDLE);
    assign tx_done = r_tx_done;
    assign state   = r_state;

endmodule
